// File: rtl/serial_magnitude_comparator.sv
// serial_magnitude_comparator
//
// Digit-serial, MSB-first magnitude comparator. Compares two WIDTH-bit
// operands DIGIT bits per clock and stops at the first unequal digit. If all
// digits are equal, the captured cascade inputs (gti/lti/eqi) from a
// less-significant stage become the result.
//
// Parameters:
//   WIDTH : operand width in bits (>= 2)
//   DIGIT : bits compared per cycle; must divide WIDTH (N = WIDTH/DIGIT)
//
// Ports:
//   clk         : clock, rising edge
//   rst         : synchronous active-high reset
//   start       : request, accepted only in IDLE
//   A, B        : operands, captured on accept
//   signed_mode : 1 = two's-complement compare, captured on accept
//   gti/lti/eqi : cascade inputs, captured on accept
//   busy        : high while digits are being compared
//   done        : one-cycle pulse when gto/lto/eqo carry a new result
//   gto/lto/eqo : A > B / A < B / A == B, held until the next done or reset

module serial_magnitude_comparator #(
  parameter int WIDTH = 24,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             signed_mode,
  input  logic             gti,
  input  logic             lti,
  input  logic             eqi,
  output logic             busy,
  output logic             done,
  output logic             gto,
  output logic             lto,
  output logic             eqo
);

  localparam int N  = WIDTH / DIGIT;
  // Keep the counter at least one bit wide for the single-digit case.
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [CW-1:0]    cnt;
  logic             gti_q;
  logic             lti_q;
  logic             eqi_q;

  logic [DIGIT-1:0] a_dig;
  logic [DIGIT-1:0] b_dig;
  logic             dig_ne;
  logic             last_dig;

  // The operands are shifted left each RUN cycle, so the digit under
  // comparison always sits in the top DIGIT bits.
  assign a_dig    = a_sh[WIDTH-1 -: DIGIT];
  assign b_dig    = b_sh[WIDTH-1 -: DIGIT];
  assign dig_ne   = (a_dig != b_dig);
  assign last_dig = (cnt == CW'(N - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (dig_ne || last_dig) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Operand capture, digit stepping and result registers. In signed mode the
  // sign bits are flipped once at capture; this maps two's-complement order
  // onto unsigned order and only affects the MSB digit.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh  <= '0;
      b_sh  <= '0;
      cnt   <= '0;
      gti_q <= 1'b0;
      lti_q <= 1'b0;
      eqi_q <= 1'b0;
      gto   <= 1'b0;
      lto   <= 1'b0;
      eqo   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sh  <= A ^ {signed_mode, {(WIDTH-1){1'b0}}};
            b_sh  <= B ^ {signed_mode, {(WIDTH-1){1'b0}}};
            cnt   <= '0;
            gti_q <= gti;
            lti_q <= lti;
            eqi_q <= eqi;
          end
        end
        RUN: begin
          if (dig_ne) begin
            gto <= (a_dig > b_dig);
            lto <= (a_dig < b_dig);
            eqo <= 1'b0;
          end else if (last_dig) begin
            gto <= gti_q;
            lto <= lti_q;
            eqo <= eqi_q;
          end else begin
            cnt  <= cnt + CW'(1);
            a_sh <= a_sh << DIGIT;
            b_sh <= b_sh << DIGIT;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
